// File: rtl/xif_copro_result_tx.sv
// xif_copro_result_tx: buffers coprocessor results and returns only committed ones to the core
module xif_copro_result_tx #(
   parameter int DEPTH    = 4,
   parameter int ID_WIDTH = 4,
   parameter int XLEN     = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                exec_valid_i,
   output logic                exec_ready_o,
   input  logic [ID_WIDTH-1:0] exec_id_i,
   input  logic [XLEN-1:0]     exec_data_i,
   input  logic [4:0]          exec_rd_i,
   input  logic                exec_we_i,
   input  logic                commit_valid_i,
   input  logic [ID_WIDTH-1:0] commit_id_i,
   input  logic                commit_kill_i,
   output logic                result_valid_o,
   input  logic                result_ready_i,
   output logic [ID_WIDTH-1:0] result_id_o,
   output logic [XLEN-1:0]     result_data_o,
   output logic [4:0]          result_rd_o,
   output logic                result_we_o
);
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int NID = 2 ** ID_WIDTH;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [ID_WIDTH-1:0] id;
      logic [XLEN-1:0]     data;
      logic [4:0]          rd;
      logic                we;
   } entry_t;

   entry_t         mem_q [DEPTH];
   entry_t         mem_d [DEPTH];
   logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [NID-1:0] seen_q, seen_d, kill_q, kill_d;
   entry_t         head;
   logic           head_seen, offer, drop, push, pop;

   // Head decode: offer committed heads, drop killed heads, hold uncommitted ones
   always_comb begin
      head           = mem_q[rptr_q];
      head_seen      = (count_q != '0) && seen_q[head.id];
      offer          = head_seen && !kill_q[head.id];
      drop           = head_seen && kill_q[head.id];
      exec_ready_o   = count_q != FULL;
      push           = exec_valid_i && exec_ready_o;
      pop            = drop || (offer && result_ready_i);
      result_valid_o = offer;
      result_id_o    = offer ? head.id : '0;
      result_data_o  = offer ? head.data : '0;
      result_rd_o    = offer ? head.rd : '0;
      result_we_o    = offer ? head.we : 1'b0;
   end

   // Next state: FIFO write/read and commit table; a commit set wins over a pop clear
   always_comb begin
      mem_d = mem_q;
      if (push)
         mem_d[wptr_q] = '{id: exec_id_i, data: exec_data_i, rd: exec_rd_i,
                           we: exec_we_i && (exec_rd_i != 5'd0)};
      wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q + CW'(push) - CW'(pop);
      seen_d  = seen_q;
      kill_d  = kill_q;
      if (pop) begin
         seen_d[head.id] = 1'b0;
         kill_d[head.id] = 1'b0;
      end
      if (commit_valid_i) begin
         seen_d[commit_id_i] = 1'b1;
         kill_d[commit_id_i] = commit_kill_i;
      end
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         seen_q  <= '0;
         kill_q  <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         seen_q  <= seen_d;
         kill_q  <= kill_d;
      end
   end

`ifndef SYNTHESIS
   logic          dup;
   logic [AW-1:0] off;

   // Flag a push whose ID is still held by an entry that is not leaving this cycle
   always_comb begin
      dup = 1'b0;
      off = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = AW'(i) - rptr_q;
         if (({1'b0, off} < count_q) && !(pop && (AW'(i) == rptr_q)) && (mem_q[i].id == exec_id_i))
            dup = 1'b1;
      end
   end

   a_unique_id: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> !dup)
      else $error("push with an id already in flight");
   a_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (result_valid_o && !result_ready_i) |=> (result_valid_o &&
      $stable({result_id_o, result_data_o, result_rd_o, result_we_o})))
      else $error("result payload changed before acceptance");
`endif
endmodule

// File: tb/tb_xif_copro_result_tx.sv
// tb_xif_copro_result_tx: directed stimulus checked against a queue-based model of the result path
module tb_xif_copro_result_tx;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
   } ent_t;

   logic        clk = 0, rst_n = 0;
   logic        exec_valid = 0, exec_ready;
   logic [3:0]  exec_id = 0;
   logic [31:0] exec_data = 0;
   logic [4:0]  exec_rd = 0;
   logic        exec_we = 0;
   logic        commit_valid = 0, commit_kill = 0;
   logic [3:0]  commit_id = 0;
   logic        result_valid, result_ready = 0;
   logic [3:0]  result_id;
   logic [31:0] result_data;
   logic [4:0]  result_rd;
   logic        result_we;

   int errors = 0, checks = 0;
   ent_t mq[$];
   bit [15:0] mseen = '0, mkill = '0;
   logic [3:0] got[$];

   xif_copro_result_tx #(.DEPTH(DEPTH), .ID_WIDTH(4), .XLEN(32)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .exec_valid_i(exec_valid), .exec_ready_o(exec_ready), .exec_id_i(exec_id),
      .exec_data_i(exec_data), .exec_rd_i(exec_rd), .exec_we_i(exec_we),
      .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
      .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
      .result_data_o(result_data), .result_rd_o(result_rd), .result_we_o(result_we)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: in-order queue plus commit table; outputs checked every falling edge, state advanced for the next rising edge
   always @(negedge clk) begin
      ent_t e;
      bit hv, hd, full;
      logic [3:0] h;
      e = '0; hv = 0; hd = 0;
      if (!rst_n) begin
         mq.delete(); mseen = '0; mkill = '0;
         chk("rst_valid", result_valid, 0);
         chk("rst_payload", {result_id, result_data, result_rd, result_we}, 0);
      end else begin
         full = mq.size() == DEPTH;
         if (mq.size() > 0 && mseen[mq[0].id]) begin
            if (mkill[mq[0].id]) hd = 1;
            else begin hv = 1; e = mq[0]; end
         end
         chk("exec_ready", exec_ready, !full);
         chk("result_valid", result_valid, hv);
         chk("payload", {result_id, result_data, result_rd, result_we}, e);
         if (result_valid && result_ready) got.push_back(result_id);
         if (hd || (hv && result_ready)) begin
            h = mq[0].id;
            void'(mq.pop_front());
            mseen[h] = 0; mkill[h] = 0;
         end
         if (exec_valid && !full)
            mq.push_back('{id: exec_id, data: exec_data, rd: exec_rd, we: exec_we && exec_rd != 0});
         if (commit_valid) begin mseen[commit_id] = 1; mkill[commit_id] = commit_kill; end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push(input logic [3:0] id, input logic [31:0] d, input logic [4:0] rd, input logic we);
      exec_valid = 1; exec_id = id; exec_data = d; exec_rd = rd; exec_we = we;
      tick();
      exec_valid = 0;
   endtask

   task automatic commit(input logic [3:0] id, input logic k);
      commit_valid = 1; commit_id = id; commit_kill = k;
      tick();
      commit_valid = 0;
   endtask

   initial begin
      logic [3:0] exp_order[13] = '{3, 1, 4, 5, 6, 7, 8, 9, 10, 11, 12, 14, 1};
      #2;
      chk("lit_reset_valid", result_valid, 0);
      chk("lit_reset_data", result_data, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      chk("lit_release_ready", exec_ready, 1);

      // commit before result: offered the cycle after the push
      commit(3, 0);
      push(3, 32'hDEADBEEF, 5, 1);
      chk("lit_cf_valid", result_valid, 1);
      chk("lit_cf_payload", {result_id, result_data, result_rd, result_we}, {4'd3, 32'hDEADBEEF, 5'd5, 1'b1});
      result_ready = 1; tick(); result_ready = 0;
      chk("lit_cf_popped", result_valid, 0);

      // result before commit, then backpressure
      push(1, 32'h11111111, 7, 1);
      repeat (5) tick();
      chk("lit_rf_hold", result_valid, 0);
      commit(1, 0);
      chk("lit_rf_valid", result_valid, 1);
      repeat (3) tick();
      chk("lit_rf_stable", {result_valid, result_id, result_data}, {1'b1, 4'd1, 32'h11111111});
      result_ready = 1; tick(); result_ready = 0;

      // kill: id 2 dropped silently, id 4 follows
      push(2, 32'h22, 8, 1);
      push(4, 32'h44, 9, 1);
      commit(2, 1);
      chk("lit_kill_hidden", result_valid, 0);
      commit(4, 0);
      chk("lit_kill_next", {result_valid, result_id, result_data}, {1'b1, 4'd4, 32'h44});
      result_ready = 1; tick(); result_ready = 0;

      // fill to full, refuse a push while full even though a pop happens
      for (int i = 0; i < 4; i++) begin
         push(4'(5 + i), 32'h50 + i, 5'(1 + i), 1);
         chk("lit_full_ready", exec_ready, i != 3);
      end
      commit(5, 0);
      result_ready = 1;
      push(13, 32'hBAD, 2, 1);
      chk("lit_full_nopush", {exec_ready, result_valid}, 2'b10);
      commit(6, 0); commit(7, 0); commit(8, 0);
      repeat (2) tick();
      result_ready = 0;

      // wrap around with a second full batch
      for (int i = 0; i < 4; i++) push(4'(9 + i), 32'h90 + i, 5'(10 + i), i[0]);
      chk("lit_wrap_full", exec_ready, 0);
      for (int i = 0; i < 4; i++) commit(4'(9 + i), 0);
      result_ready = 1;
      repeat (4) tick();
      result_ready = 0;
      chk("lit_wrap_empty", {exec_ready, result_valid}, 2'b10);

      // rd=0 suppresses we; commit in the same cycle as the push
      exec_valid = 1; exec_id = 14; exec_data = 32'hABCD; exec_rd = 0; exec_we = 1;
      commit_valid = 1; commit_id = 14; commit_kill = 0;
      tick();
      exec_valid = 0; commit_valid = 0;
      chk("lit_rd0", {result_valid, result_rd, result_we, result_data}, {1'b1, 5'd0, 1'b0, 32'hABCD});
      result_ready = 1; tick(); result_ready = 0;

      // asynchronous reset with entries pending and a result on offer
      push(1, 32'h1, 1, 1); push(2, 32'h2, 2, 1); push(3, 32'h3, 3, 1);
      commit(1, 0);
      chk("lit_prereset_valid", result_valid, 1);
      #2 rst_n = 0;
      #1 chk("lit_async_drop", result_valid, 0);
      @(posedge clk); #1 rst_n = 1;
      chk("lit_postreset_ready", exec_ready, 1);
      push(1, 32'h77, 3, 1);
      chk("lit_table_cleared", result_valid, 0);
      commit(1, 0);
      chk("lit_post_payload", {result_valid, result_id, result_data}, {1'b1, 4'd1, 32'h77});
      result_ready = 1; tick(); result_ready = 0;
      tick();

      chk("lit_order_len", got.size(), 13);
      for (int i = 0; i < 13; i++)
         chk("lit_order", (i < got.size()) ? got[i] : 4'hx, exp_order[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
